// File: rtl/rv_imm_pkg.sv
// -----------------------------------------------------------------------------
// rv_imm_pkg
// Shared definitions for the RISC-V instruction encoder:
//   - imm_src_e   : immediate / instruction format select codes
//   - ERR_*       : bit positions inside the 3-bit error flag vector
//   - OP_*        : commonly used base opcodes
//   - enc_req_t   : raw request fields as captured by the first pipeline stage
//   - fits_signed : true when a 32-bit value is the sign extension of its
//                   low nbits bits
// -----------------------------------------------------------------------------
package rv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_R    = 3'b101,
        IMM_ILL6 = 3'b110,
        IMM_ILL7 = 3'b111
    } imm_src_e;

    localparam int ERR_RANGE    = 0;
    localparam int ERR_MISALIGN = 1;
    localparam int ERR_ILLEGAL  = 2;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] LUI    = 7'h37;

    typedef struct packed {
        imm_src_e    imm_src;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } enc_req_t;

    // Arithmetic right shift leaves only copies of the sign bit when the
    // value fits: the upper part is then all zeros or all ones.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned nbits);
        logic [31:0] upper;
        upper = $signed(value) >>> (nbits - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Request/response bundle of the instruction encoder.
//   Request  : in_valid, in_ready, imm_src, imm, opcode, rd, rs1, rs2,
//              funct3, funct7
//   Response : out_valid, out_ready, out_instr, out_err
// Modports:
//   master : the side that issues requests and consumes encoded words
//   slave  : the encoder itself
// -----------------------------------------------------------------------------
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_err;

    modport master (
        output in_valid, imm_src, imm, opcode, rd, rs1, rs2, funct3, funct7,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, imm_src, imm, opcode, rd, rs1, rs2, funct3, funct7,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/instr_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack
// Purely combinational: packs the raw request fields into a 32-bit RISC-V
// instruction word for the selected format and flags encoding problems.
// Ports:
//   req   in  enc_req_t  raw fields (format, immediate, registers, functs)
//   instr out 32         encoded word (zero for illegal format codes)
//   err   out 3          {illegal, misalign, range}
// Range and misalign problems still produce the word from truncated fields.
// -----------------------------------------------------------------------------
module instr_field_pack
    import rv_imm_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] instr,
    output logic [2:0]  err
);

    // NOTE: combinational outputs get a default before the case so every
    // path assigns them and no latch is inferred.
    always_comb begin
        instr = '0;
        err   = '0;
        case (req.imm_src)
            IMM_I: begin
                instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                err[ERR_RANGE] = !fits_signed(req.imm, 12);
            end
            IMM_S: begin
                instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:0], req.opcode};
                err[ERR_RANGE] = !fits_signed(req.imm, 12);
            end
            IMM_B: begin
                instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:1], req.imm[11], req.opcode};
                err[ERR_RANGE]    = !fits_signed(req.imm, 13);
                err[ERR_MISALIGN] = req.imm[0];
            end
            IMM_U: begin
                instr = {req.imm[31:12], req.rd, req.opcode};
                err[ERR_RANGE] = (req.imm[11:0] != 12'h000);
            end
            IMM_J: begin
                instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                         req.rd, req.opcode};
                err[ERR_RANGE]    = !fits_signed(req.imm, 21);
                err[ERR_MISALIGN] = req.imm[0];
            end
            IMM_R: begin
                instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            default: begin
                err[ERR_ILLEGAL] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Two-stage pipelined RISC-V instruction encoder with valid/ready handshakes.
//   Stage A holds the raw accepted request; instr_field_pack encodes it;
//   stage B holds the encoded word and error flags until drained.
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset
//   bus       slave modport of instr_encoder_if (request and response sides)
//   err_count out 8   saturating count of drained transactions with errors
// -----------------------------------------------------------------------------
module instr_encoder
    import rv_imm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus,
    output logic [7:0]       err_count
);

    logic        valid_a;
    logic        valid_b;
    logic        advance_b;
    logic        in_ready;
    logic        accept;
    enc_req_t    req_in;
    enc_req_t    req_a;
    logic [31:0] pack_instr;
    logic [2:0]  pack_err;
    logic [31:0] instr_b;
    logic [2:0]  err_b;

    // Stage B can take a new word when empty or when its word leaves now;
    // stage A can take a request when empty or when it moves into B now.
    assign advance_b = !valid_b || bus.out_ready;
    assign in_ready  = !valid_a || advance_b;
    assign accept    = bus.in_valid && in_ready;

    always_comb begin
        req_in.imm_src = imm_src_e'(bus.imm_src);
        req_in.imm     = bus.imm;
        req_in.opcode  = bus.opcode;
        req_in.rd      = bus.rd;
        req_in.rs1     = bus.rs1;
        req_in.rs2     = bus.rs2;
        req_in.funct3  = bus.funct3;
        req_in.funct7  = bus.funct7;
    end

    // Stage A occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a <= 1'b0;
        end else if (in_ready) begin
            valid_a <= bus.in_valid;
        end
    end

    // NOTE: the stage A payload has no reset; it is only ever observed
    // qualified by valid_a, which is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_a <= req_in;
        end
    end

    instr_field_pack u_pack (
        .req   (req_a),
        .instr (pack_instr),
        .err   (pack_err)
    );

    // Stage B payload is reset because it drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_b <= 1'b0;
            instr_b <= '0;
            err_b   <= '0;
        end else if (advance_b) begin
            valid_b <= valid_a;
            if (valid_a) begin
                instr_b <= pack_instr;
                err_b   <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (valid_b && bus.out_ready && (err_b != '0) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_b;
    assign bus.out_instr = instr_b;
    assign bus.out_err   = err_b;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have these ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 The block SHALL have these input-side ports: in_valid in 1, request valid; in_ready out 1, request accepted when both are high at a clk edge.
REQ-003 The block SHALL have these field inputs: imm_src in 3, format select; imm in 32, immediate value; opcode in 7; rd in 5; rs1 in 5; rs2 in 5; funct3 in 3; funct7 in 7.
REQ-004 The block SHALL have these output-side ports: out_valid out 1; out_ready in 1; out_instr out 32, encoded instruction; out_err out 3, error flags.
REQ-005 The block SHALL have err_count out 8, a saturating count of errored transactions.

Function
REQ-006 imm_src encoding SHALL be: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110/111 illegal.
REQ-007 All formats SHALL place opcode in [6:0].
REQ-008 I format SHALL place imm[11:0] in [31:20], rs1 in [19:15], funct3 in [14:12] and rd in [11:7].
REQ-009 S format SHALL place imm[11:5] in [31:25], rs2 in [24:20], rs1, funct3 and imm[4:0] in [11:7].
REQ-010 B format SHALL place imm[12] in [31], imm[10:5] in [30:25], rs2, rs1, funct3, imm[4:1] in [11:8] and imm[11] in [7].
REQ-011 U format SHALL place imm[31:12] in [31:12] and rd in [11:7].
REQ-012 J format SHALL place imm[20] in [31], imm[10:1] in [30:21], imm[11] in [20], imm[19:12] in [19:12] and rd in [11:7].
REQ-013 R format SHALL place funct7 in [31:25], then rs2, rs1, funct3 and rd; imm is ignored.
REQ-014 out_err[0] (range) SHALL be set when imm is not the sign extension of its low 12 bits (I/S), 13 bits (B) or 21 bits (J), or when imm[11:0] is nonzero (U).
REQ-015 out_err[1] (misalign) SHALL be set for B or J formats when imm[0]=1.
REQ-016 out_err[2] (illegal) SHALL be set for imm_src 110/111, and out_instr SHALL then be 0x00000000.
REQ-017 Range and misalign errors SHALL still produce out_instr from the truncated fields as listed above.
REQ-018 The datapath SHALL be two register stages: stage A captures raw inputs on acceptance; stage B captures the encoded word and flags from stage A.
REQ-019 advance_B SHALL be !valid_B or out_ready.
REQ-020 in_ready SHALL be !valid_A or advance_B, evaluated combinationally with no dependency on in_valid.
REQ-021 A request accepted at edge k SHALL appear on out_valid/out_instr/out_err after edge k+1 when not stalled.
REQ-022 Sustained throughput SHALL be one transaction per cycle while out_ready=1.
REQ-023 out_instr and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Transactions SHALL leave in acceptance order, with none lost or duplicated.
REQ-025 Simultaneous accept and drain SHALL both occur in the same cycle when stages are full and out_ready=1.
REQ-026 err_count SHALL increment by 1 on each out_valid&out_ready handshake with out_err!=0, and saturate at 255.

Reset
REQ-027 rst_n low SHALL immediately clear valid_A, valid_B and err_count, so that out_valid=0, out_instr=0, out_err=0 and err_count=0 regardless of clk.
REQ-028 In-flight transactions at reset SHALL be discarded; in_ready SHALL read 1 while in reset.
REQ-029 The first acceptance after reset SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-030 The imm_src codes, error bit indices and opcode constants (OP_IMM 0x13, BRANCH 0x63, JAL 0x6F, LUI 0x37) SHALL live in shared package rv_imm_pkg.
REQ-031 Field packing and error checking SHALL be one combinational sub-module, instr_field_pack, placed between stage A and stage B.
REQ-032 Pipeline control and err_count SHALL live in instr_encoder.

Verification
REQ-033 The bench SHALL drive I: imm=0xFFFFFFFF, rd=1, rs1=0, funct3=0, opcode=0x13 -> out_instr=0xFFF00093, out_err=0, one edge after the accepting edge.
REQ-034 The bench SHALL drive B: imm=8, rs1=1, rs2=2, funct3=0, opcode=0x63 -> out_instr=0x00208463, out_err=0.
REQ-035 The bench SHALL drive J: imm=0x800, rd=1, opcode=0x6F -> 0x001000EF; then B with imm=3 -> out_err=010 and err_count increments to 1 on drain.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles while offering 3 back-to-back requests -> exactly 2 accepted and in_ready=0 thereafter; on release, outputs appear in order, with the third accepted in the same cycle as the first drain.
REQ-037 The bench SHALL assert rst_n low mid-cycle with both stages full and err_count=3 -> out_valid=0 and err_count=0 before the next clk edge, with no stale output after release.
REQ-038 The bench SHALL run a randomized legal-immediate round trip: decoding out_instr per REQ-008..REQ-013 SHALL return imm and all register fields for 10k transactions with random out_ready.
